// File: rtl/rv32_writeback_buffer.sv
// ---------------------------------------------------------------------------
// rv32_writeback_buffer
//   Write-side front end of the 32x32 RV32I register file. Retired results
//   (rd, data) are accepted over a valid/ready port and queued in order in a
//   DEPTH-entry FIFO. The FIFO drains one entry per cycle into the register
//   file write port. The register file captures on the negedge inside the
//   cycle, and the head is popped on the following posedge. A two-port bypass
//   lookup returns the youngest queued value for a source register, so that
//   queued-but-unwritten results are never read stale.
//
// Ports
//   clock, async_reset            posedge clock, asynchronous active-low reset
//   in_valid/in_ready/in_rd/in_data  producer port (results to be written)
//   wb_stall                      regfile port borrowed elsewhere; hold head
//   rf_write_en/addr/data         register file write port (combinational)
//   byp_addr_k -> byp_hit_k/byp_data_k  bypass lookup, k = 1, 2
//   count                         number of entries currently queued
//
// Handshake: a transfer happens on a posedge where in_valid && in_ready.
//   in_ready does not depend on in_valid. A result for x0 completes the
//   handshake but is discarded.
// ---------------------------------------------------------------------------
module rv32_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         async_reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_rd,
  input  logic [31:0]                  in_data,
  input  logic                         wb_stall,
  output logic                         rf_write_en,
  output logic [4:0]                   rf_write_addr,
  output logic [31:0]                  rf_write_data,
  input  logic [4:0]                   byp_addr_1,
  input  logic [4:0]                   byp_addr_2,
  output logic                         byp_hit_1,
  output logic [31:0]                  byp_data_1,
  output logic                         byp_hit_2,
  output logic [31:0]                  byp_data_2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          not_empty;
  logic          pop;
  logic          push;
  logic [PW-1:0] byp_idx;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty && !wb_stall;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH)) || pop;
  assign push      = in_valid && in_ready && (in_rd != 5'd0);

  // Drain port: driven straight from the head entry.
  assign rf_write_en   = pop;
  assign rf_write_addr = not_empty ? rd_q[head_q]   : 5'd0;
  assign rf_write_data = not_empty ? data_q[head_q] : 32'd0;
  assign count         = count_q;

  // Pointers are PW bits wide and DEPTH is a power of two, so the
  // increments wrap modulo DEPTH on their own.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // When full with a simultaneous pop, tail == head: the head slot is
  // overwritten on the same edge it is consumed, which is safe because the
  // write port already read it during the cycle.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else if (push) begin
      rd_q[tail_q]   <= in_rd;
      data_q[tail_q] <= in_data;
    end
  end

  // Bypass: walk live entries oldest to youngest so that the last match,
  // the youngest one, is the value that remains.
  always_comb begin
    byp_hit_1  = 1'b0;
    byp_data_1 = 32'd0;
    byp_hit_2  = 1'b0;
    byp_data_2 = 32'd0;
    byp_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      byp_idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((byp_addr_1 != 5'd0) && (rd_q[byp_idx] == byp_addr_1)) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = data_q[byp_idx];
        end
        if ((byp_addr_2 != 5'd0) && (rd_q[byp_idx] == byp_addr_2)) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = data_q[byp_idx];
        end
      end
    end
  end

endmodule
